// File: rtl/crc4_word_checker.sv
// crc4_word_checker
// Receive-side integrity stage for one data lane. Accepts a data word with its
// CRC-4, recomputes the CRC over the word one byte per cycle (MSB first) and
// presents the word downstream together with a pass/fail flag. Keeps a
// wrapping count of checked words and a saturating count of failed words.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_data     data word from the lane
//   in_crc      received CRC for in_data
//   in_valid    upstream word present
//   in_ready    block can accept a word (IDLE)
//   out_data    copy of the accepted word
//   out_crc_ok  1 = recomputed CRC equals received CRC
//   out_valid   result present (OUT)
//   out_ready   downstream accepts result
//   cnt_clr     synchronous clear of both counters (wins over an update)
//   word_cnt    words checked, wraps
//   err_cnt     words failing CRC, saturates at all-ones
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// CALC  | folding one byte per cycle into the running CRC
// OUT   | result held on out_* until out_ready
module crc4_word_checker #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] POLY   = 4'h3,
  parameter int         CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_crc,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_crc_ok,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          crc_q, crc_d;
  logic [3:0]          crc_in_q, crc_in_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ok_q, ok_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [7:0]          cur_byte;
  logic [3:0]          crc_step;
  logic                word_done;
  logic                word_bad;

  // Eight serial LFSR steps, MSB of the byte first.
  function automatic logic [3:0] crc_byte(input logic [3:0] c_in, input logic [7:0] b);
    logic [3:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[3] ^ b[i];
      c  = {c[2:0], 1'b0} ^ (fb ? POLY : 4'h0);
    end
    return c;
  endfunction

  always_comb begin
    cur_byte = data_q[DATA_W-1-8*int'(idx_q) -: 8];
    crc_step = crc_byte(crc_q, cur_byte);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    crc_in_d  = crc_in_q;
    data_d    = data_q;
    ok_d      = ok_q;
    word_done = 1'b0;
    word_bad  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          crc_in_d = in_crc;
          crc_d    = 4'h0;
          idx_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        crc_d = crc_step;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d   = ST_OUT;
          ok_d      = (crc_step == crc_in_q);
          word_done = 1'b1;
          word_bad  = (crc_step != crc_in_q);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear takes priority over a coinciding count so the cleared word is lost.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (word_done) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (word_bad && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      crc_q      <= 4'h0;
      crc_in_q   <= 4'h0;
      data_q     <= '0;
      ok_q       <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      crc_in_q   <= crc_in_d;
      data_q     <= data_d;
      ok_q       <= ok_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign out_data   = data_q;
  assign out_crc_ok = ok_q;
  assign word_cnt   = word_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_crc4_word_checker.sv
// Testbench for crc4_word_checker. A second instance with 4-bit counters
// shares all inputs so counter wrap and saturation are reached quickly.
module tb_crc4_word_checker;

  logic        clock;
  logic        reset_n;
  logic [63:0] in_data;
  logic [3:0]  in_crc;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_crc_ok;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;

  logic        s_in_ready;
  logic [63:0] s_out_data;
  logic        s_out_crc_ok;
  logic        s_out_valid;
  logic [3:0]  s_word_cnt;
  logic [3:0]  s_err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  crc4_word_checker #(.DATA_W(64), .POLY(4'h3), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_crc(in_crc), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_crc_ok(out_crc_ok), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  crc4_word_checker #(.DATA_W(64), .POLY(4'h3), .CNT_W(4)) dut_s (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_crc(in_crc), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_crc_ok(s_out_crc_ok), .out_valid(s_out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .word_cnt(s_word_cnt), .err_cnt(s_err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] ref_crc(input logic [63:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 63; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  // Caller sits on a negedge with the DUT idle; accept happens at the next posedge.
  task automatic drive_word(input logic [63:0] d, input logic [3:0] c);
    in_data  = d;
    in_crc   = c;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_crc   = 4'($urandom);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    in_crc    = '0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_crc_ok !== 1'b0) $display("FAIL reset_ok got %b want 0", out_crc_ok); else n_pass++;
    n_checks++; if (out_data !== 64'h0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_checks++; if (word_cnt !== 16'h0) $display("FAIL reset_word_cnt got %h want 0", word_cnt); else n_pass++;
    n_checks++; if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt got %h want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_zero_word();
    int cyc;
    drive_word(64'h0, 4'h0);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL zero_busy got in_ready=%b want 0", in_ready); else n_pass++;
    wait_result(cyc);
    n_checks++; if (cyc !== 8) $display("FAIL zero_latency got %0d want 8", cyc); else n_pass++;
    n_checks++; if (out_crc_ok !== 1'b1) $display("FAIL zero_ok got %b want 1", out_crc_ok); else n_pass++;
    n_checks++; if (word_cnt !== 16'd1) $display("FAIL zero_word_cnt got %0d want 1", word_cnt); else n_pass++;
    n_checks++; if (err_cnt !== 16'd0) $display("FAIL zero_err_cnt got %0d want 0", err_cnt); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL zero_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_single_bits();
    logic [63:0] vd [3] = '{64'h1, 64'h2, 64'h8};
    logic [3:0]  vc [3] = '{4'h3, 4'h6, 4'h3};
    logic        vok[3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] verr[3] = '{16'd0, 16'd0, 16'd1};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      drive_word(vd[i], vc[i]);
      wait_result(cyc);
      n_checks++; if (out_crc_ok !== vok[i]) $display("FAIL bits%0d_ok got %b want %b", i, out_crc_ok, vok[i]); else n_pass++;
      n_checks++; if (out_data !== vd[i]) $display("FAIL bits%0d_data got %h want %h", i, out_data, vd[i]); else n_pass++;
      n_checks++; if (err_cnt !== verr[i]) $display("FAIL bits%0d_err_cnt got %0d want %0d", i, err_cnt, verr[i]); else n_pass++;
      n_checks++; if (word_cnt !== 16'(i + 2)) $display("FAIL bits%0d_word_cnt got %0d want %0d", i, word_cnt, i + 2); else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    out_ready = 1'b0;
    drive_word(64'h8, 4'hB);
    wait_result(cyc);
    n_checks++; if (out_crc_ok !== 1'b1) $display("FAIL bp_ok got %b want 1", out_crc_ok); else n_pass++;
    // A competing word sits on the input the whole time and must not be taken.
    in_data  = 64'h2;
    in_crc   = 4'h6;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_data !== 64'h8 || in_ready !== 1'b0 || out_crc_ok !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (word_cnt !== 16'd5) $display("FAIL bp_word_cnt got %0d want 5", word_cnt); else n_pass++;
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    wait_result(cyc);
    n_checks++; if (cyc !== 8 || out_data !== 64'h2 || out_crc_ok !== 1'b1)
      $display("FAIL bp_next got lat=%0d data=%h ok=%b want 8/2/1", cyc, out_data, out_crc_ok); else n_pass++;
    n_checks++; if (word_cnt !== 16'd6 || err_cnt !== 16'd1)
      $display("FAIL bp_counts got %0d/%0d want 6/1", word_cnt, err_cnt); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_counters();
    int cyc;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive_word(64'h8, 4'h3);
      wait_result(cyc);
      if (i == 14) begin
        n_checks++; if (s_word_cnt !== 4'hF || s_err_cnt !== 4'hF)
          $display("FAIL cnt_full got %h/%h want F/F", s_word_cnt, s_err_cnt); else n_pass++;
      end
      @(negedge clock);
    end
    n_checks++; if (s_word_cnt !== 4'h0) $display("FAIL cnt_wrap got %h want 0", s_word_cnt); else n_pass++;
    n_checks++; if (s_err_cnt !== 4'hF) $display("FAIL cnt_sat got %h want F", s_err_cnt); else n_pass++;
    n_checks++; if (word_cnt !== 16'd16 || err_cnt !== 16'd16)
      $display("FAIL cnt_wide got %0d/%0d want 16/16", word_cnt, err_cnt); else n_pass++;
    drive_word(64'h8, 4'h3);
    repeat (7) @(negedge clock);
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_crc_ok !== 1'b0)
      $display("FAIL clr_result got valid=%b ok=%b want 1/0", out_valid, out_crc_ok); else n_pass++;
    n_checks++; if (word_cnt !== 16'd0 || err_cnt !== 16'd0)
      $display("FAIL clr_wide got %0d/%0d want 0/0", word_cnt, err_cnt); else n_pass++;
    n_checks++; if (s_word_cnt !== 4'h0 || s_err_cnt !== 4'h0)
      $display("FAIL clr_narrow got %h/%h want 0/0", s_word_cnt, s_err_cnt); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    drive_word(64'hDEAD_BEEF_0123_4567, 4'h5);
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_crc_ok !== 1'b0 || out_data !== 64'h0)
      $display("FAIL rst_outputs got valid=%b ok=%b data=%h want 0/0/0", out_valid, out_crc_ok, out_data); else n_pass++;
    n_checks++; if (word_cnt !== 16'd0 || err_cnt !== 16'd0)
      $display("FAIL rst_counts got %0d/%0d want 0/0", word_cnt, err_cnt); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_idle got ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    drive_word(64'h1, 4'h3);
    wait_result(cyc);
    n_checks++; if (cyc !== 8 || out_crc_ok !== 1'b1 || word_cnt !== 16'd1 || err_cnt !== 16'd0)
      $display("FAIL rst_next got lat=%0d ok=%b cnt=%0d/%0d want 8/1/1/0", cyc, out_crc_ok, word_cnt, err_cnt); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_stress();
    int cyc;
    int n_bad;
    int ok_err;
    logic [63:0] d;
    logic [3:0]  c;
    logic        exp_ok;
    apply_reset();
    n_bad  = 0;
    ok_err = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      d = {$urandom, $urandom};
      c = ref_crc(d);
      exp_ok = 1'b1;
      if ($urandom_range(0, 99) < 30) begin
        c = c ^ 4'($urandom_range(1, 15));
        exp_ok = 1'b0;
        n_bad++;
      end
      drive_word(d, c);
      wait_result(cyc);
      out_ready = 1'b0;
      if (cyc >= 40 || out_crc_ok !== exp_ok || out_data !== d) begin
        ok_err++;
        if (ok_err <= 5)
          $display("FAIL stress_word%0d got ok=%b data=%h want ok=%b data=%h", i, out_crc_ok, out_data, exp_ok, d);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      out_ready = 1'b1;
      @(negedge clock);
    end
    n_checks++; if (ok_err !== 0) $display("FAIL stress_results got %0d bad words want 0", ok_err); else n_pass++;
    n_checks++; if (word_cnt !== 16'd1000) $display("FAIL stress_word_cnt got %0d want 1000", word_cnt); else n_pass++;
    n_checks++; if (err_cnt !== 16'(n_bad)) $display("FAIL stress_err_cnt got %0d want %0d", err_cnt, n_bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_single_bits();
    test_backpressure();
    test_counters();
    test_reset_mid_calc();
    test_stress();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
